exception_ctrl: RTL and testbench
=================================

Name: exception_ctrl

Overview:
Exception/interrupt sequencing stage sitting directly downstream of the main controller decoder in the LEGv8 core. Consumes the decoder's Exc, EStatus and Eret outputs and the asynchronous ExtIRQ line. Captures return address (ELR) and syndrome (ESR), redirects fetch to the exception vector, and drives the ExcAck / ExtIAck handshakes. Also masks interrupts while a handler runs and flags double faults.

Parameters:
PC_W, 64, width of PC and ELR
ESR_W, 4, width of EStatus/ESR syndrome
EXC_VECTOR, 64'h0000_0000_0000_00D8, handler entry address
SYNC_STAGES, 2, ExtIRQ synchronizer depth (>=2)
ESR_IRQ, 4'h1, syndrome code written for external interrupt

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
Exc  in  1  decoder-flagged synchronous exception for the current instruction
EStatus  in  ESR_W  syndrome from decoder, valid when Exc=1
Eret  in  1  current instruction is ERET
ExtIRQ  in  1  external interrupt request, asynchronous level, held until acked
PC  in  PC_W  address of instruction currently in execute
ExcAck  out  1  one-cycle pulse: current instruction suppressed, vector taken
ExtIAck  out  1  one-cycle pulse: interrupt accepted
PCSelExc  out  1  next PC = EVAddr this cycle
EVAddr  out  PC_W  exception vector (constant EXC_VECTOR)
ELR  out  PC_W  exception link register
ESR  out  ESR_W  exception syndrome register
InHandler  out  1  handler active, IRQs masked
DoubleFault  out  1  sticky; sync exception raised inside handler

Behaviour:
- Reset (reset=0, async): state=IDLE; ELR=0, ESR=0, DoubleFault=0, synchronizer flops=0, irq_rearm=1; all pulse outputs 0.
- ExtIRQ passes through SYNC_STAGES flops -> irq_s. irq_pending = irq_s & irq_rearm & state==IDLE.
- States: IDLE, TAKE, HANDLER.
- IDLE:
  - Exc=1: ELR<=PC, ESR<=EStatus, take_irq<=0 -> TAKE. Exc has priority over irq_pending in the same cycle; IRQ stays pending.
  - Else if irq_pending: ELR<=PC (instruction re-executed after return), ESR<=ESR_IRQ, take_irq<=1, irq_rearm<=0 -> TAKE.
  - Eret in IDLE: ignored, no state change.
- TAKE (exactly one cycle):
  - ExcAck=1, PCSelExc=1, ExtIAck=take_irq.
  - Datapath suppresses register/memory writes of the instruction at ELR.
  - -> HANDLER.
- HANDLER:
  - InHandler=1; IRQs masked (irq_pending forced 0).
  - Eret=1 -> IDLE next cycle; datapath loads PC from ELR, which holds stable through that cycle.
  - Exc=1 (nested): DoubleFault<=1 (sticky), ESR<=EStatus, ELR unchanged -> TAKE (re-vector).
  - Eret and Exc in the same cycle: Exc wins.
- Interrupt handshake:
  - irq_rearm is set to 1 only when irq_s is observed 0.
  - An irq held high after ExtIAck is therefore never taken twice.
- Latency: Exc to ExcAck is 1 cycle. ExtIRQ rise to ExtIAck is SYNC_STAGES+1 cycles minimum (with IDLE and no Exc).
- Reset mid-TAKE or mid-HANDLER: immediate return to reset values; pending handshake is dropped.
- ELR/ESR are written only on IDLE->TAKE, or ESR only on nested Exc; otherwise held.

Decomposition:
- Shared package exc_pkg:
  - state enum exc_state_t {IDLE, TAKE, HANDLER}
  - ESR code constants (ESR_NONE=0, ESR_IRQ=1, ESR_INVOP=2)
  - EXC_VECTOR default
- One sub-module: sync_ff (parameterised SYNC_STAGES level synchronizer, async active-low reset) for ExtIRQ.

Test Plan:
- Reset asserted mid-run -> ELR=0, ESR=0, DoubleFault=0, InHandler=0, ExcAck=ExtIAck=PCSelExc=0 immediately (async).
- PC=0x40, Exc=1, EStatus=2 -> next cycle ExcAck=1, PCSelExc=1, EVAddr=0xD8, ExtIAck=0; ELR=0x40, ESR=2; then InHandler=1.
- ExtIRQ raised and held, PC=0x100 -> ExtIAck pulses once 3 cycles later; ELR=0x100, ESR=1; with ExtIRQ still high after Eret, no second ack until ExtIRQ drops and rises again.
- Exc and irq_pending in the same cycle (PC=0x80, EStatus=2) -> ESR=2, ExtIAck=0. After Eret, the IRQ is taken: ESR=1, ExtIAck=1.
- In HANDLER, ExtIRQ toggles -> no ExcAck; Eret -> IDLE, ELR stable; IRQ taken afterwards.
- Nested Exc in HANDLER with EStatus=3 -> DoubleFault=1 sticky, ESR=3, ELR unchanged, ExcAck pulses again.

Source files
------------

// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared types and constants for the exception sequencing stage
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        HANDLER = 2'd2
    } exc_state_t;

    localparam logic [3:0] ESR_NONE  = 4'h0;
    localparam logic [3:0] ESR_IRQ   = 4'h1;
    localparam logic [3:0] ESR_INVOP = 4'h2;

    localparam logic [63:0] EXC_VECTOR = 64'h0000_0000_0000_00D8;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop level synchronizer for a single asynchronous input
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - exception/interrupt sequencer: captures ELR/ESR, vectors fetch, acks IRQs
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int                PC_W        = 64,
    parameter int                ESR_W       = 4,
    parameter logic [PC_W-1:0]   EXC_VECTOR  = PC_W'(exc_pkg::EXC_VECTOR),
    parameter int                SYNC_STAGES = 2,
    parameter logic [ESR_W-1:0]  ESR_IRQ     = ESR_W'(exc_pkg::ESR_IRQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Exc,
    input  logic [ESR_W-1:0] EStatus,
    input  logic             Eret,
    input  logic             ExtIRQ,
    input  logic [PC_W-1:0]  PC,
    output logic             ExcAck,
    output logic             ExtIAck,
    output logic             PCSelExc,
    output logic [PC_W-1:0]  EVAddr,
    output logic [PC_W-1:0]  ELR,
    output logic [ESR_W-1:0] ESR,
    output logic             InHandler,
    output logic             DoubleFault
);

    exc_state_t       state, state_nxt;
    logic [PC_W-1:0]  elr_q;
    logic [ESR_W-1:0] esr_q, esr_nxt;
    logic             elr_we, esr_we;
    logic             take_irq, take_irq_nxt;
    logic             irq_s, irq_rearm, irq_pending;
    logic             rearm_clr, df_set;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (ExtIRQ),
        .q     (irq_s)
    );

    assign irq_pending = irq_s && irq_rearm && (state == IDLE);

    always_comb begin
        state_nxt    = state;
        elr_we       = 1'b0;
        esr_we       = 1'b0;
        esr_nxt      = esr_q;
        take_irq_nxt = take_irq;
        rearm_clr    = 1'b0;
        df_set       = 1'b0;
        unique case (state)
            IDLE: begin
                // A synchronous exception wins; the IRQ stays pending for after ERET.
                if (Exc) begin
                    elr_we       = 1'b1;
                    esr_we       = 1'b1;
                    esr_nxt      = EStatus;
                    take_irq_nxt = 1'b0;
                    state_nxt    = TAKE;
                end else if (irq_pending) begin
                    elr_we       = 1'b1;
                    esr_we       = 1'b1;
                    esr_nxt      = ESR_IRQ;
                    take_irq_nxt = 1'b1;
                    rearm_clr    = 1'b1;
                    state_nxt    = TAKE;
                end
            end
            TAKE: begin
                state_nxt = HANDLER;
            end
            HANDLER: begin
                if (Exc) begin
                    df_set       = 1'b1;
                    esr_we       = 1'b1;
                    esr_nxt      = EStatus;
                    take_irq_nxt = 1'b0;
                    state_nxt    = TAKE;
                end else if (Eret) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            elr_q       <= '0;
            esr_q       <= '0;
            take_irq    <= 1'b0;
            irq_rearm   <= 1'b1;
            DoubleFault <= 1'b0;
        end else begin
            state    <= state_nxt;
            take_irq <= take_irq_nxt;
            if (elr_we) elr_q <= PC;
            if (esr_we) esr_q <= esr_nxt;
            if (df_set) DoubleFault <= 1'b1;
            // Re-arming only on an observed low keeps a held request from being acked twice.
            if (!irq_s) begin
                irq_rearm <= 1'b1;
            end else if (rearm_clr) begin
                irq_rearm <= 1'b0;
            end
        end
    end

    assign ExcAck    = (state == TAKE);
    assign PCSelExc  = (state == TAKE);
    assign ExtIAck   = (state == TAKE) && take_irq;
    assign InHandler = (state == HANDLER);
    assign EVAddr    = EXC_VECTOR;
    assign ELR       = elr_q;
    assign ESR       = esr_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - directed self-checking bench for exception_ctrl
module tb_exception_ctrl;

    localparam int PC_W  = 64;
    localparam int ESR_W = 4;

    logic             clk;
    logic             reset;
    logic             Exc;
    logic [ESR_W-1:0] EStatus;
    logic             Eret;
    logic             ExtIRQ;
    logic [PC_W-1:0]  PC;
    logic             ExcAck;
    logic             ExtIAck;
    logic             PCSelExc;
    logic [PC_W-1:0]  EVAddr;
    logic [PC_W-1:0]  ELR;
    logic [ESR_W-1:0] ESR;
    logic             InHandler;
    logic             DoubleFault;

    int vectors;
    int miscompares;

    exception_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .Exc         (Exc),
        .EStatus     (EStatus),
        .Eret        (Eret),
        .ExtIRQ      (ExtIRQ),
        .PC          (PC),
        .ExcAck      (ExcAck),
        .ExtIAck     (ExtIAck),
        .PCSelExc    (PCSelExc),
        .EVAddr      (EVAddr),
        .ELR         (ELR),
        .ESR         (ESR),
        .InHandler   (InHandler),
        .DoubleFault (DoubleFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; Exc = 1'b0; EStatus = '0; Eret = 1'b0; ExtIRQ = 1'b0; PC = '0;
        tick(2);
        vectors++;
        if ({ExcAck, ExtIAck, PCSelExc, InHandler, DoubleFault} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags got=%b exp=00000", {ExcAck, ExtIAck, PCSelExc, InHandler, DoubleFault});
        end
        vectors++;
        if (ELR !== 64'h0 || ESR !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_regs got ELR=%h ESR=%h exp ELR=0 ESR=0", ELR, ESR);
        end
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_sync_exc;
        PC = 64'h40; Exc = 1'b1; EStatus = 4'h2;
        tick(1);
        Exc = 1'b0;
        vectors++;
        if ({ExcAck, PCSelExc, ExtIAck, InHandler} !== 4'b1100) begin
            miscompares++;
            $display("FAIL exc_take_flags got=%b exp=1100", {ExcAck, PCSelExc, ExtIAck, InHandler});
        end
        vectors++;
        if (EVAddr !== 64'hD8) begin
            miscompares++;
            $display("FAIL exc_evaddr got=%h exp=d8", EVAddr);
        end
        vectors++;
        if (ELR !== 64'h40 || ESR !== 4'h2) begin
            miscompares++;
            $display("FAIL exc_capture got ELR=%h ESR=%h exp ELR=40 ESR=2", ELR, ESR);
        end
        PC = 64'hD8;
        tick(1);
        vectors++;
        if ({InHandler, ExcAck, PCSelExc} !== 3'b100) begin
            miscompares++;
            $display("FAIL exc_handler got=%b exp=100", {InHandler, ExcAck, PCSelExc});
        end
        Eret = 1'b1;
        tick(1);
        Eret = 1'b0;
        vectors++;
        if (InHandler !== 1'b0 || ELR !== 64'h40) begin
            miscompares++;
            $display("FAIL exc_eret got InHandler=%b ELR=%h exp 0 40", InHandler, ELR);
        end
    endtask

    task automatic test_irq;
        int acks;
        logic found;
        PC = 64'h100; ExtIRQ = 1'b1;
        tick(2);
        vectors++;
        if (ExtIAck !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_early_ack got=%b exp=0", ExtIAck);
        end
        tick(1);
        vectors++;
        if ({ExtIAck, ExcAck, PCSelExc} !== 3'b111) begin
            miscompares++;
            $display("FAIL irq_ack_latency got=%b exp=111", {ExtIAck, ExcAck, PCSelExc});
        end
        vectors++;
        if (ELR !== 64'h100 || ESR !== 4'h1) begin
            miscompares++;
            $display("FAIL irq_capture got ELR=%h ESR=%h exp ELR=100 ESR=1", ELR, ESR);
        end
        tick(1);
        Eret = 1'b1;
        tick(1);
        Eret = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (ExcAck || ExtIAck) acks++;
        end
        vectors++;
        if (acks !== 0) begin
            miscompares++;
            $display("FAIL irq_held_no_reack got acks=%0d exp=0", acks);
        end
        ExtIRQ = 1'b0;
        tick(3);
        ExtIRQ = 1'b1;
        PC = 64'h120;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick(1);
            if (ExtIAck) found = 1'b1;
        end
        vectors++;
        if (found !== 1'b1 || ELR !== 64'h120) begin
            miscompares++;
            $display("FAIL irq_rearm_ack got found=%b ELR=%h exp 1 120", found, ELR);
        end
        ExtIRQ = 1'b0;
        tick(1);
        Eret = 1'b1;
        tick(1);
        Eret = 1'b0;
        tick(3);
    endtask

    task automatic test_exc_irq_priority;
        ExtIRQ = 1'b1;
        tick(2);
        PC = 64'h80; Exc = 1'b1; EStatus = 4'h2;
        tick(1);
        Exc = 1'b0;
        vectors++;
        if (ESR !== 4'h2 || ExtIAck !== 1'b0 || ExcAck !== 1'b1 || ELR !== 64'h80) begin
            miscompares++;
            $display("FAIL prio_exc_first got ESR=%h ExtIAck=%b ExcAck=%b ELR=%h exp 2 0 1 80", ESR, ExtIAck, ExcAck, ELR);
        end
        tick(1);
        Eret = 1'b1;
        tick(1);
        Eret = 1'b0;
        PC = 64'h84;
        tick(1);
        vectors++;
        if (ESR !== 4'h1 || ExtIAck !== 1'b1 || ELR !== 64'h84) begin
            miscompares++;
            $display("FAIL prio_irq_after got ESR=%h ExtIAck=%b ELR=%h exp 1 1 84", ESR, ExtIAck, ELR);
        end
        tick(1);
    endtask

    task automatic test_handler_mask;
        int acks;
        logic found;
        logic [5:0] pattern;
        pattern = 6'b111000;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            ExtIRQ = pattern[i];
            tick(1);
            if (ExcAck || ExtIAck) acks++;
        end
        vectors++;
        if (acks !== 0 || InHandler !== 1'b1) begin
            miscompares++;
            $display("FAIL mask_in_handler got acks=%0d InHandler=%b exp 0 1", acks, InHandler);
        end
        PC = 64'h200; Eret = 1'b1;
        tick(1);
        Eret = 1'b0;
        vectors++;
        if (ELR !== 64'h84 || InHandler !== 1'b0) begin
            miscompares++;
            $display("FAIL mask_eret_elr got ELR=%h InHandler=%b exp 84 0", ELR, InHandler);
        end
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            tick(1);
            if (ExtIAck) found = 1'b1;
        end
        vectors++;
        if (found !== 1'b1 || ESR !== 4'h1 || ELR !== 64'h200) begin
            miscompares++;
            $display("FAIL mask_irq_after got found=%b ESR=%h ELR=%h exp 1 1 200", found, ESR, ELR);
        end
        ExtIRQ = 1'b0;
        tick(1);
    endtask

    task automatic test_nested;
        PC = 64'h300; Exc = 1'b1; EStatus = 4'h3;
        tick(1);
        Exc = 1'b0;
        vectors++;
        if ({ExcAck, ExtIAck, DoubleFault} !== 3'b101) begin
            miscompares++;
            $display("FAIL nested_flags got=%b exp=101", {ExcAck, ExtIAck, DoubleFault});
        end
        vectors++;
        if (ESR !== 4'h3 || ELR !== 64'h200) begin
            miscompares++;
            $display("FAIL nested_regs got ESR=%h ELR=%h exp 3 200", ESR, ELR);
        end
        tick(1);
        Eret = 1'b1; Exc = 1'b1; EStatus = 4'h2;
        tick(1);
        Exc = 1'b0;
        vectors++;
        if (ExcAck !== 1'b1 || ESR !== 4'h2) begin
            miscompares++;
            $display("FAIL nested_exc_beats_eret got ExcAck=%b ESR=%h exp 1 2", ExcAck, ESR);
        end
        tick(1);
        tick(1);
        Eret = 1'b0;
        vectors++;
        if (InHandler !== 1'b0 || DoubleFault !== 1'b1) begin
            miscompares++;
            $display("FAIL nested_sticky got InHandler=%b DoubleFault=%b exp 0 1", InHandler, DoubleFault);
        end
        Eret = 1'b1;
        tick(2);
        Eret = 1'b0;
        vectors++;
        if ({ExcAck, InHandler} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_eret_ignored got=%b exp=00", {ExcAck, InHandler});
        end
    endtask

    task automatic test_reset_mid;
        PC = 64'h500; Exc = 1'b1; EStatus = 4'h2;
        tick(1);
        Exc = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({ExcAck, ExtIAck, PCSelExc, InHandler, DoubleFault} !== 5'b0 || ELR !== 64'h0 || ESR !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_mid got flags=%b ELR=%h ESR=%h exp 00000 0 0",
                     {ExcAck, ExtIAck, PCSelExc, InHandler, DoubleFault}, ELR, ESR);
        end
        #1;
        reset = 1'b1;
        tick(2);
        vectors++;
        if ({ExcAck, InHandler} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mid_idle got=%b exp=00", {ExcAck, InHandler});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset;
        test_sync_exc;
        test_irq;
        test_exc_irq_priority;
        test_handler_mask;
        test_nested;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
